// File: rtl/snn_pkg.sv
// Shared sorter state encoding and default image geometry for the SNN rank-order input path.
package snn_pkg;

    localparam int IMAGE_SIZE_DEFAULT      = 5;
    localparam int PIXEL_MAX_VALUE_DEFAULT = 10;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        EMIT,
        WAIT_LO,
        DONE
    } sorter_state_t;

endpackage

// File: rtl/sorter_pixel_mem.sv
// Image store: one saturating write port, asynchronous read mux on the scan index, cleared on reset.
module sorter_pixel_mem
    import snn_pkg::*;
#(
    parameter int IMAGE_SIZE      = IMAGE_SIZE_DEFAULT,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_MAX_VALUE = PIXEL_MAX_VALUE_DEFAULT,
    parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [IMAGE_SIZE_BITS:0] waddr,
    input  logic [PIXEL_BITS-1:0]    wdata,
    input  logic [IMAGE_SIZE_BITS:0] raddr,
    output logic [PIXEL_BITS-1:0]    rdata
);

    localparam int IW = IMAGE_SIZE_BITS + 1;
    localparam logic [PIXEL_BITS-1:0] PIX_MAX = PIXEL_BITS'(PIXEL_MAX_VALUE);

    logic [PIXEL_BITS-1:0] mem_q [IMAGE_SIZE];
    logic [PIXEL_BITS-1:0] mem_d [IMAGE_SIZE];
    logic [PIXEL_BITS-1:0] wdata_sat;

    // Out-of-range addresses match no entry, so such writes fall away naturally.
    always_comb begin
        wdata_sat = (wdata > PIX_MAX) ? PIX_MAX : wdata;
        for (int i = 0; i < IMAGE_SIZE; i++) begin
            mem_d[i] = mem_q[i];
            if (we && (waddr == IW'(i))) begin
                mem_d[i] = wdata_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < IMAGE_SIZE; i++) begin
            if (raddr == IW'(i)) begin
                rdata = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/pixel_rank_sorter.sv
// Emits pixel indices in descending value order, ascending index within a value, paced by the AER encoder.
// Optional build macro SORTER_EMIT_ZERO_EN extends the scan through level 0 so zero pixels are emitted last.
module pixel_rank_sorter
    import snn_pkg::*;
#(
    parameter int IMAGE_SIZE      = IMAGE_SIZE_DEFAULT,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_MAX_VALUE = PIXEL_MAX_VALUE_DEFAULT,
    parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IMG_WE,
    input  logic [IMAGE_SIZE_BITS:0] IMG_ADDR,
    input  logic [PIXEL_BITS-1:0]    IMG_DATA,
    input  logic                     START,
    input  logic                     AERIN_CTRL_BUSY,
    output logic [IMAGE_SIZE_BITS:0] NEXT_INDEX,
    output logic                     FOUND_NEXT_INDEX,
    output logic                     SORT_BUSY,
    output logic                     SORT_DONE
);

    localparam int IW = IMAGE_SIZE_BITS + 1;
    localparam logic [IW-1:0]         IDX_LAST  = IW'(IMAGE_SIZE - 1);
    localparam logic [PIXEL_BITS-1:0] LEVEL_MAX = PIXEL_BITS'(PIXEL_MAX_VALUE);
`ifdef SORTER_EMIT_ZERO_EN
    localparam logic [PIXEL_BITS-1:0] LEVEL_MIN = '0;
`else
    localparam logic [PIXEL_BITS-1:0] LEVEL_MIN = PIXEL_BITS'(1);
`endif

    sorter_state_t         state_q, state_d;
    logic [PIXEL_BITS-1:0] level_q, level_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         next_index_q, next_index_d;
    logic                  found_q, found_d;

    logic [PIXEL_BITS-1:0] pixel_rd;
    logic                  mem_we;
    logic                  idx_wrap;
    logic                  scan_last;
    logic [IW-1:0]         idx_adv;
    logic [PIXEL_BITS-1:0] level_adv;

    assign mem_we = IMG_WE && (state_q == IDLE);

    sorter_pixel_mem #(
        .IMAGE_SIZE      (IMAGE_SIZE),
        .IMAGE_SIZE_BITS (IMAGE_SIZE_BITS),
        .PIXEL_MAX_VALUE (PIXEL_MAX_VALUE),
        .PIXEL_BITS      (PIXEL_BITS)
    ) u_mem (
        .clk   (CLK),
        .rst   (RST),
        .we    (mem_we),
        .waddr (IMG_ADDR),
        .wdata (IMG_DATA),
        .raddr (idx_q),
        .rdata (pixel_rd)
    );

    // Shared index/level advance used both after a miss in SCAN and after a completed handshake.
    always_comb begin
        idx_wrap  = (idx_q == IDX_LAST);
        scan_last = idx_wrap && (level_q == LEVEL_MIN);
        idx_adv   = idx_wrap ? '0 : idx_q + IW'(1);
        level_adv = (idx_wrap && !scan_last) ? level_q - PIXEL_BITS'(1) : level_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            level_q      <= '0;
            idx_q        <= '0;
            next_index_q <= '0;
            found_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            idx_q        <= idx_d;
            next_index_q <= next_index_d;
            found_q      <= found_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        idx_d        = idx_q;
        next_index_d = next_index_q;
        found_d      = found_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = SCAN;
                    level_d = LEVEL_MAX;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (!AERIN_CTRL_BUSY) begin
                    if (pixel_rd == level_q) begin
                        state_d      = EMIT;
                        next_index_d = idx_q;
                        found_d      = 1'b1;
                    end else begin
                        idx_d   = idx_adv;
                        level_d = level_adv;
                        if (scan_last) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            EMIT: begin
                if (AERIN_CTRL_BUSY) begin
                    found_d = 1'b0;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!AERIN_CTRL_BUSY) begin
                    idx_d   = idx_adv;
                    level_d = level_adv;
                    state_d = scan_last ? DONE : SCAN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        SORT_BUSY        = (state_q != IDLE);
        SORT_DONE        = (state_q == DONE);
        NEXT_INDEX       = next_index_q;
        FOUND_NEXT_INDEX = found_q;
    end

endmodule
